command_arbiter: RTL and testbench

COMMAND_ARBITER -- requirements
Module: command_arbiter

---
 rtl/command_arbiter.sv | 151 +++++++++++++++
 tb/tb_command_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_arbiter.sv
// command_arbiter: round-robin arbiter issuing two requesters' commands to a host under
// tag and credit flow control, with odd-parity checking and sticky fault on bad responses.
module command_arbiter #(
    parameter int TAG_COUNT = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][12:0] req_command,
    input  logic [1:0][63:0] req_address,
    input  logic [1:0][11:0] req_size,
    input  logic [15:0]      context_handle,
    input  logic [7:0]       room,
    output logic             cmd_valid,
    output logic [7:0]       cmd_tag,
    output logic             cmd_tag_parity,
    output logic [12:0]      cmd_command,
    output logic             cmd_command_parity,
    output logic [2:0]       cmd_abt,
    output logic [63:0]      cmd_address,
    output logic             cmd_address_parity,
    output logic [15:0]      cmd_context_handle,
    output logic [11:0]      cmd_size,
    input  logic             rsp_valid,
    input  logic [7:0]       rsp_tag,
    input  logic             rsp_tag_parity,
    input  logic [7:0]       rsp_response,
    input  logic [8:0]       rsp_credits,
    output logic             done_valid,
    output logic             done_requester,
    output logic [7:0]       done_response,
    output logic             error
);
    typedef enum logic [1:0] {INIT, RUN, FAULT} state_t;
    state_t                 state_q, state_d;
    logic [TAG_COUNT-1:0]   busy_q, busy_d, owner_q, owner_d;
    logic signed [8:0]      credits_q, credits_d;
    logic                   prio_q, prio_d;
    logic                   cmd_valid_q, cmd_tag_par_q, cmd_command_par_q, cmd_address_par_q;
    logic [7:0]             cmd_tag_q;
    logic [12:0]            cmd_command_q;
    logic [63:0]            cmd_address_q;
    logic [15:0]            cmd_context_q;
    logic [11:0]            cmd_size_q;
    logic                   done_valid_q, done_req_q, error_q;
    logic [7:0]             done_resp_q;
    logic                   free_any, gnt_sel, grant, rsp_hit, rsp_owner, rsp_live, rsp_ok, rsp_bad;
    logic [7:0]             free_tag;

    always_comb begin
        free_any  = 1'b0;
        free_tag  = '0;
        rsp_hit   = 1'b0;
        rsp_owner = 1'b0;
        for (int t = TAG_COUNT - 1; t >= 0; t--) begin
            if (!busy_q[t]) begin
                free_any = 1'b1;
                free_tag = 8'(t);
            end
            if (busy_q[t] && rsp_tag == 8'(t)) begin
                rsp_hit   = 1'b1;
                rsp_owner = owner_q[t];
            end
        end
        gnt_sel   = req_valid[prio_q] ? prio_q : ~prio_q;
        req_ready = '0;
        if (state_q == RUN && credits_q > 9'sd0 && free_any && req_valid[gnt_sel])
            req_ready[gnt_sel] = 1'b1;
        grant     = |req_ready;
        // Out-of-range tags never match a busy bit, so rsp_hit also covers the range check.
        rsp_live  = rsp_valid && state_q != INIT;
        rsp_ok    = rsp_live && rsp_tag_parity == ~^rsp_tag && rsp_hit;
        rsp_bad   = rsp_live && !rsp_ok;
        busy_d    = busy_q;
        owner_d   = owner_q;
        for (int t = 0; t < TAG_COUNT; t++) begin
            if (rsp_ok && rsp_tag == 8'(t))
                busy_d[t] = 1'b0;
            if (grant && free_tag == 8'(t)) begin
                busy_d[t]  = 1'b1;
                owner_d[t] = gnt_sel;
            end
        end
        credits_d = state_q == INIT ? {1'b0, room}
                  : credits_q - {8'd0, grant} + (rsp_ok ? rsp_credits : 9'd0);
        prio_d    = grant ? ~gnt_sel : prio_q;
        state_d   = state_q == INIT ? RUN : (rsp_bad ? FAULT : state_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q           <= INIT;
            busy_q            <= '0;
            owner_q           <= '0;
            credits_q         <= '0;
            prio_q            <= 1'b0;
            cmd_valid_q       <= 1'b0;
            cmd_tag_q         <= '0;
            cmd_tag_par_q     <= 1'b0;
            cmd_command_q     <= '0;
            cmd_command_par_q <= 1'b0;
            cmd_address_q     <= '0;
            cmd_address_par_q <= 1'b0;
            cmd_context_q     <= '0;
            cmd_size_q        <= '0;
            done_valid_q      <= 1'b0;
            done_req_q        <= 1'b0;
            done_resp_q       <= '0;
            error_q           <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            owner_q      <= owner_d;
            credits_q    <= credits_d;
            prio_q       <= prio_d;
            cmd_valid_q  <= grant;
            if (grant) begin
                cmd_tag_q         <= free_tag;
                cmd_tag_par_q     <= ~^free_tag;
                cmd_command_q     <= req_command[gnt_sel];
                cmd_command_par_q <= ~^req_command[gnt_sel];
                cmd_address_q     <= req_address[gnt_sel];
                cmd_address_par_q <= ~^req_address[gnt_sel];
                cmd_context_q     <= context_handle;
                cmd_size_q        <= req_size[gnt_sel];
            end
            done_valid_q <= rsp_ok;
            if (rsp_ok) begin
                done_req_q  <= rsp_owner;
                done_resp_q <= rsp_response;
            end
            error_q      <= error_q | rsp_bad;
        end
    end

    assign cmd_valid          = cmd_valid_q;
    assign cmd_tag            = cmd_tag_q;
    assign cmd_tag_parity     = cmd_tag_par_q;
    assign cmd_command        = cmd_command_q;
    assign cmd_command_parity = cmd_command_par_q;
    assign cmd_abt            = 3'd0;
    assign cmd_address        = cmd_address_q;
    assign cmd_address_parity = cmd_address_par_q;
    assign cmd_context_handle = cmd_context_q;
    assign cmd_size           = cmd_size_q;
    assign done_valid         = done_valid_q;
    assign done_requester     = done_req_q;
    assign done_response      = done_resp_q;
    assign error              = error_q;
endmodule

// File: tb/tb_command_arbiter.sv
// tb_command_arbiter: directed and randomized checks of command_arbiter against a
// cycle-level behavioural model of tags, credits and round-robin priority.
module tb_command_arbiter;
    logic             clock = 1'b0, reset = 1'b0;
    logic [1:0]       req_valid = '0, req_ready;
    logic [1:0][12:0] req_command = '0;
    logic [1:0][63:0] req_address = '0;
    logic [1:0][11:0] req_size = '0;
    logic [15:0]      context_handle = '0;
    logic [7:0]       room = '0;
    logic             cmd_valid, cmd_tag_parity, cmd_command_parity, cmd_address_parity;
    logic [7:0]       cmd_tag;
    logic [12:0]      cmd_command;
    logic [2:0]       cmd_abt;
    logic [63:0]      cmd_address;
    logic [15:0]      cmd_context_handle;
    logic [11:0]      cmd_size;
    logic             rsp_valid = 1'b0, rsp_tag_parity = 1'b0;
    logic [7:0]       rsp_tag = '0, rsp_response = '0;
    logic [8:0]       rsp_credits = '0;
    logic             done_valid, done_requester, error;
    logic [7:0]       done_response;

    command_arbiter #(.TAG_COUNT(8)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_command(req_command), .req_address(req_address), .req_size(req_size),
        .context_handle(context_handle), .room(room), .cmd_valid(cmd_valid), .cmd_tag(cmd_tag),
        .cmd_tag_parity(cmd_tag_parity), .cmd_command(cmd_command),
        .cmd_command_parity(cmd_command_parity), .cmd_abt(cmd_abt), .cmd_address(cmd_address),
        .cmd_address_parity(cmd_address_parity), .cmd_context_handle(cmd_context_handle),
        .cmd_size(cmd_size), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
        .rsp_tag_parity(rsp_tag_parity), .rsp_response(rsp_response), .rsp_credits(rsp_credits),
        .done_valid(done_valid), .done_requester(done_requester), .done_response(done_response),
        .error(error)
    );

    always #5 clock = ~clock;

    int checks = 0, failures = 0;
    bit mbusy[8], mowner[8];
    int mcred, mprio, mstate;
    bit merr;
    logic [1:0]  seen_ready, exp_ready;
    bit          exp_cv, exp_dv;
    logic [7:0]  exp_tag, exp_dresp;
    logic        exp_tp, exp_cp, exp_ap, exp_dr;
    logic [12:0] exp_cmd;
    logic [63:0] exp_addr;
    logic [11:0] exp_size;
    logic [15:0] exp_ctx;

    function automatic logic odd_bit(input logic [63:0] v);
        return ($countones(v) % 2) == 0;
    endfunction

    task automatic assert_reset();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            mbusy[i] = 0;
            mowner[i] = 0;
        end
        mcred = 0; mprio = 0; mstate = 0; merr = 0; exp_cv = 0; exp_dv = 0;
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic restart(input logic [7:0] r, input logic [1:0] rv);
        rsp_valid = 0;
        req_valid = rv;
        room = r;
        assert_reset();
        release_reset();
    endtask

    task automatic set_rsp(input logic [7:0] tag, input bit good, input logic [8:0] cr, input logic [7:0] resp);
        rsp_valid = 1; rsp_tag = tag; rsp_credits = cr; rsp_response = resp;
        rsp_tag_parity = good ? odd_bit(64'(tag)) : ~odd_bit(64'(tag));
    endtask

    // One clock of the reference model: decide from pre-edge state, apply after the edge.
    task automatic tick();
        logic [1:0] r;
        int ft, t, g;
        bit live, ok;
        @(negedge clock);
        seen_ready = req_ready;
        r = 0;
        ft = -1;
        for (int i = 7; i >= 0; i--) if (!mbusy[i]) ft = i;
        if (mstate == 1 && mcred > 0 && ft >= 0) begin
            if (req_valid[mprio]) r[mprio] = 1;
            else if (req_valid[1-mprio]) r[1-mprio] = 1;
        end
        exp_ready = r;
        t = int'(rsp_tag);
        live = rsp_valid && mstate != 0;
        ok = live && ($countones({rsp_tag, rsp_tag_parity}) % 2 == 1) && t < 8 && (t < 8 ? mbusy[t] : 0);
        @(posedge clock);
        if (mstate == 0) begin
            mstate = 1;
            mcred = int'(room);
            exp_cv = 0;
            exp_dv = 0;
        end else begin
            exp_cv = r != 0;
            exp_dv = ok;
            if (ok) begin
                mbusy[t] = 0;
                exp_dr = mowner[t];
                exp_dresp = rsp_response;
                mcred += int'($signed(rsp_credits));
            end
            if (r != 0) begin
                g = r[1] ? 1 : 0;
                mbusy[ft] = 1;
                mowner[ft] = g[0];
                exp_tag = 8'(ft);
                exp_tp = odd_bit(64'(ft));
                exp_cmd = req_command[g];
                exp_cp = odd_bit(64'(req_command[g]));
                exp_addr = req_address[g];
                exp_ap = odd_bit(req_address[g]);
                exp_size = req_size[g];
                exp_ctx = context_handle;
                mprio = 1 - g;
                mcred--;
            end
            if (live && !ok) begin
                mstate = 2;
                merr = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        assert_reset();
        checks++;
        if ({req_ready, cmd_valid, done_valid, error, cmd_tag, cmd_tag_parity, cmd_command_parity,
             cmd_address_parity, cmd_abt, done_requester, done_response} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b cv=%b dv=%b err=%b tag=%0d tp=%b exp all zero",
                     req_ready, cmd_valid, done_valid, error, cmd_tag, cmd_tag_parity);
        end
        release_reset();
    endtask

    task automatic test_two_credits();
        req_command[0] = 13'h0AA; req_command[1] = 13'h155;
        req_address[0] = 64'h1111; req_address[1] = 64'h2222;
        req_size[0] = 12'h040; req_size[1] = 12'h080;
        context_handle = 16'hBEEF;
        restart(8'd2, 2'b11);
        tick();
        checks++;
        if (seen_ready !== 2'b00) begin failures++; $display("FAIL init_ready got=%b exp=00", seen_ready); end
        tick();
        checks++;
        if ({seen_ready, cmd_valid, cmd_tag, cmd_tag_parity, cmd_command, cmd_context_handle, cmd_size} !==
            {2'b01, 1'b1, 8'd0, 1'b1, 13'h0AA, 16'hBEEF, 12'h040}) begin
            failures++;
            $display("FAIL grant_req0 got ready=%b cv=%b tag=%0d cmd=%h exp ready=01 cv=1 tag=0 cmd=0aa",
                     seen_ready, cmd_valid, cmd_tag, cmd_command);
        end
        tick();
        checks++;
        if ({seen_ready, cmd_valid, cmd_tag, cmd_tag_parity, cmd_address} !== {2'b10, 1'b1, 8'd1, 1'b0, 64'h2222}) begin
            failures++;
            $display("FAIL grant_req1 got ready=%b cv=%b tag=%0d tp=%b exp ready=10 cv=1 tag=1 tp=0",
                     seen_ready, cmd_valid, cmd_tag, cmd_tag_parity);
        end
        tick();
        checks++;
        if ({seen_ready, cmd_valid} !== 3'b000) begin
            failures++;
            $display("FAIL no_credit got ready=%b cv=%b exp ready=00 cv=0", seen_ready, cmd_valid);
        end
    endtask

    task automatic test_parity();
        bit par_exp[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        req_command[0] = 13'h0003;
        req_address[0] = 64'h1;
        restart(8'd8, 2'b01);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({cmd_valid, cmd_tag, cmd_tag_parity, cmd_command_parity, cmd_address_parity, cmd_abt} !==
                {1'b1, 8'(i), par_exp[i], 1'b1, 1'b0, 3'd0}) begin
                failures++;
                $display("FAIL parity_tag%0d got cv=%b tag=%0d tp=%b cp=%b ap=%b exp cv=1 tag=%0d tp=%b cp=1 ap=0",
                         i, cmd_valid, cmd_tag, cmd_tag_parity, cmd_command_parity, cmd_address_parity, i, par_exp[i]);
            end
        end
    endtask

    task automatic test_tag_reuse();
        restart(8'd8, 2'b01);
        tick();
        repeat (8) tick();
        set_rsp(8'd1, 1, 9'd1, 8'h5A);
        tick();
        checks++;
        if ({seen_ready, cmd_valid, done_valid, done_requester, done_response} !== {2'b00, 1'b0, 1'b1, 1'b0, 8'h5A}) begin
            failures++;
            $display("FAIL reuse_rsp got ready=%b cv=%b dv=%b dr=%b resp=%h exp ready=00 cv=0 dv=1 dr=0 resp=5a",
                     seen_ready, cmd_valid, done_valid, done_requester, done_response);
        end
        rsp_valid = 0;
        tick();
        checks++;
        if ({seen_ready, cmd_valid, cmd_tag, done_valid} !== {2'b01, 1'b1, 8'd1, 1'b0}) begin
            failures++;
            $display("FAIL reuse_grant got ready=%b cv=%b tag=%0d dv=%b exp ready=01 cv=1 tag=1 dv=0",
                     seen_ready, cmd_valid, cmd_tag, done_valid);
        end
    endtask

    task automatic test_same_cycle_credit();
        restart(8'd2, 2'b01);
        tick();
        tick();
        set_rsp(8'd0, 1, 9'd1, 8'h33);
        tick();
        checks++;
        if ({seen_ready, cmd_valid, cmd_tag, done_valid} !== {2'b01, 1'b1, 8'd1, 1'b1}) begin
            failures++;
            $display("FAIL credit_same_cycle got ready=%b cv=%b tag=%0d dv=%b exp ready=01 cv=1 tag=1 dv=1",
                     seen_ready, cmd_valid, cmd_tag, done_valid);
        end
        rsp_valid = 0;
        tick();
        checks++;
        if ({seen_ready, cmd_valid, cmd_tag} !== {2'b01, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL credit_kept got ready=%b cv=%b tag=%0d exp ready=01 cv=1 tag=0", seen_ready, cmd_valid, cmd_tag);
        end
        tick();
        checks++;
        if (seen_ready !== 2'b00) begin failures++; $display("FAIL credit_spent got=%b exp=00", seen_ready); end
    endtask

    task automatic test_fault();
        restart(8'd4, 2'b01);
        tick();
        tick();
        tick();
        req_valid = 0;
        set_rsp(8'd0, 0, 9'd1, 8'h11);
        tick();
        checks++;
        if ({error, done_valid} !== 2'b10) begin
            failures++;
            $display("FAIL fault_parity got err=%b dv=%b exp err=1 dv=0", error, done_valid);
        end
        rsp_valid = 0;
        req_valid = 2'b01;
        tick();
        checks++;
        if ({seen_ready, cmd_valid} !== 3'b000) begin
            failures++;
            $display("FAIL fault_blocks got ready=%b cv=%b exp ready=00 cv=0", seen_ready, cmd_valid);
        end
        set_rsp(8'd1, 1, 9'd0, 8'h77);
        tick();
        checks++;
        if ({seen_ready, done_valid, done_requester, done_response, error} !== {2'b00, 1'b1, 1'b0, 8'h77, 1'b1}) begin
            failures++;
            $display("FAIL fault_done got ready=%b dv=%b dr=%b resp=%h err=%b exp ready=00 dv=1 dr=0 resp=77 err=1",
                     seen_ready, done_valid, done_requester, done_response, error);
        end
        restart(8'd4, 2'b00);
        tick();
        set_rsp(8'd5, 1, 9'd0, 8'h01);
        tick();
        checks++;
        if ({error, done_valid} !== 2'b10) begin
            failures++;
            $display("FAIL fault_free_tag got err=%b dv=%b exp err=1 dv=0", error, done_valid);
        end
        restart(8'd4, 2'b00);
        tick();
        set_rsp(8'd9, 1, 9'd0, 8'h01);
        tick();
        checks++;
        if ({error, done_valid} !== 2'b10) begin
            failures++;
            $display("FAIL fault_range got err=%b dv=%b exp err=1 dv=0", error, done_valid);
        end
    endtask

    task automatic test_reset_midop();
        restart(8'd8, 2'b01);
        repeat (4) tick();
        assert_reset();
        checks++;
        if ({req_ready, cmd_valid, cmd_tag, done_valid, error} !== '0) begin
            failures++;
            $display("FAIL midop_reset got ready=%b cv=%b tag=%0d dv=%b err=%b exp all zero",
                     req_ready, cmd_valid, cmd_tag, done_valid, error);
        end
        set_rsp(8'd9, 0, 9'd0, 8'h00);
        release_reset();
        tick();
        checks++;
        if ({seen_ready, error} !== 3'b000) begin
            failures++;
            $display("FAIL init_ignores_rsp got ready=%b err=%b exp ready=00 err=0", seen_ready, error);
        end
        rsp_valid = 0;
        tick();
        checks++;
        if ({seen_ready, cmd_valid, cmd_tag} !== {2'b01, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL midop_first_tag got ready=%b cv=%b tag=%0d exp ready=01 cv=1 tag=0", seen_ready, cmd_valid, cmd_tag);
        end
        req_valid = 0;
        set_rsp(8'd2, 1, 9'd0, 8'h00);
        tick();
        checks++;
        if ({error, done_valid} !== 2'b10) begin
            failures++;
            $display("FAIL midop_discard got err=%b dv=%b exp err=1 dv=0", error, done_valid);
        end
    endtask

    task automatic test_random();
        int busy_list[$];
        int pick;
        restart(8'($urandom_range(1, 20)), 2'b00);
        for (int c = 0; c < 400; c++) begin
            req_valid = 2'($urandom);
            for (int i = 0; i < 2; i++) begin
                req_command[i] = 13'($urandom);
                req_address[i] = {$urandom, $urandom};
                req_size[i] = 12'($urandom);
            end
            context_handle = 16'($urandom);
            busy_list.delete();
            for (int i = 0; i < 8; i++) if (mbusy[i]) busy_list.push_back(i);
            rsp_valid = 0;
            if (busy_list.size() > 0 && $urandom_range(0, 2) == 0) begin
                pick = busy_list[$urandom_range(0, busy_list.size() - 1)];
                set_rsp(8'(pick), 1, 9'($urandom_range(0, 2)), 8'($urandom));
                if (mcred > 200) rsp_credits = 9'd0;
                else if (mcred > 1 && $urandom_range(0, 7) == 0) rsp_credits = 9'h1FF;
            end
            tick();
            checks++;
            if (seen_ready !== exp_ready) begin
                failures++;
                $display("FAIL rnd_ready cycle=%0d got=%b exp=%b", c, seen_ready, exp_ready);
            end
            checks++;
            if (cmd_valid !== exp_cv || (exp_cv &&
                {cmd_tag, cmd_tag_parity, cmd_command, cmd_command_parity, cmd_address, cmd_address_parity,
                 cmd_size, cmd_context_handle, cmd_abt} !==
                {exp_tag, exp_tp, exp_cmd, exp_cp, exp_addr, exp_ap, exp_size, exp_ctx, 3'd0})) begin
                failures++;
                $display("FAIL rnd_cmd cycle=%0d got cv=%b tag=%0d cmd=%h addr=%h exp cv=%b tag=%0d cmd=%h addr=%h",
                         c, cmd_valid, cmd_tag, cmd_command, cmd_address, exp_cv, exp_tag, exp_cmd, exp_addr);
            end
            checks++;
            if (done_valid !== exp_dv || (exp_dv && {done_requester, done_response} !== {exp_dr, exp_dresp})) begin
                failures++;
                $display("FAIL rnd_done cycle=%0d got dv=%b dr=%b resp=%h exp dv=%b dr=%b resp=%h",
                         c, done_valid, done_requester, done_response, exp_dv, exp_dr, exp_dresp);
            end
            checks++;
            if (error !== merr) begin
                failures++;
                $display("FAIL rnd_error cycle=%0d got=%b exp=%b", c, error, merr);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_two_credits();
        test_parity();
        test_tag_reuse();
        test_same_cycle_credit();
        test_fault();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
